// File: rtl/mem_stage_access.sv
// mem_stage_access
//   MEM-stage data-memory access unit between the EX/MEM and MEM/WB registers.
//   Issues byte/half/word loads and stores over a req/ack handshake to a
//   variable-latency data memory. While an access is in flight it stalls the
//   pipeline. Load data is returned lane-extracted and sign- or zero-extended.
//   Misaligned accesses and memory timeouts are flagged.
//
//   Parameters
//     MAX_WAIT       REQ cycles without Mem_Ack before the access is aborted (1..255)
//   Ports
//     Clock, Reset   rising-edge clock, synchronous active-high reset
//     MemRead_In     load request from EX/MEM
//     MemWrite_In    store request from EX/MEM (wins over MemRead_In)
//     MemSize_In     00 word, 01 half, 10 byte, 11 word
//     MemSigned_In   sign-extend (1) or zero-extend (0) loads
//     Address_In     byte address
//     WriteData_In   store data in the low bits
//     Mem_Req/We/Addr/BE/WData  registered memory request, held until ack/timeout
//     Mem_RData, Mem_Ack        memory response, RData valid with the Ack pulse
//     Stall_Out      combinational pipeline hold
//     ReadData_Out   registered load result, valid in the DONE cycle
//     Misaligned_Out combinational misalignment flag (IDLE only)
//     Timeout_Out    registered one-cycle abort pulse
module mem_stage_access #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead_In,
  input  logic        MemWrite_In,
  input  logic [1:0]  MemSize_In,
  input  logic        MemSigned_In,
  input  logic [31:0] Address_In,
  input  logic [31:0] WriteData_In,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [3:0]  Mem_BE,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData,
  input  logic        Mem_Ack,
  output logic        Stall_Out,
  output logic [31:0] ReadData_Out,
  output logic        Misaligned_Out,
  output logic        Timeout_Out
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state, state_next;
  logic        access, misaligned, start, wait_expired;
  logic [7:0]  wait_cnt;
  logic [1:0]  off_q, size_q;
  logic        signed_q;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign access       = MemRead_In | MemWrite_In;
  assign start        = (state == IDLE) && access && !misaligned;
  assign wait_expired = (wait_cnt == LAST_WAIT);

  always_comb begin
    misaligned = 1'b0;
    case (MemSize_In)
      2'b01:   misaligned = Address_In[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = |Address_In[1:0];
    endcase
  end

  always_comb begin
    state_next     = state;
    Stall_Out      = 1'b0;
    Misaligned_Out = 1'b0;
    case (state)
      IDLE: begin
        Misaligned_Out = access & misaligned;
        if (start) begin
          state_next = REQ;
          Stall_Out  = 1'b1;
        end
      end
      REQ: begin
        Stall_Out = 1'b1;
        if (Mem_Ack || wait_expired) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lanes are replicated so the memory can pick whichever lane BE selects.
  always_comb begin
    be_next    = 4'hF;
    wdata_next = WriteData_In;
    case (MemSize_In)
      2'b10: begin
        be_next    = 4'b0001 << Address_In[1:0];
        wdata_next = {4{WriteData_In[7:0]}};
      end
      2'b01: begin
        be_next    = Address_In[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{WriteData_In[15:0]}};
      end
      default: begin
        be_next    = 4'hF;
        wdata_next = WriteData_In;
      end
    endcase
    if (!MemWrite_In) be_next = 4'hF;
  end

  always_comb begin
    lane_b    = Mem_RData[{off_q, 3'b000} +: 8];
    lane_h    = Mem_RData[{off_q[1], 4'b0000} +: 16];
    load_data = Mem_RData;
    case (size_q)
      2'b10:   load_data = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_data = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_data = Mem_RData;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Mem_Req      <= 1'b0;
      Mem_We       <= 1'b0;
      Mem_Addr     <= '0;
      Mem_BE       <= '0;
      Mem_WData    <= '0;
      ReadData_Out <= '0;
      Timeout_Out  <= 1'b0;
      wait_cnt     <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            Mem_Req   <= 1'b1;
            Mem_We    <= MemWrite_In;
            Mem_Addr  <= {Address_In[31:2], 2'b00};
            Mem_BE    <= be_next;
            Mem_WData <= wdata_next;
            wait_cnt  <= '0;
            off_q     <= Address_In[1:0];
            size_q    <= MemSize_In;
            signed_q  <= MemSigned_In;
          end
        end
        REQ: begin
          if (Mem_Ack) begin
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
            if (!Mem_We) ReadData_Out <= load_data;
          end else if (wait_expired) begin
            Mem_Req      <= 1'b0;
            Mem_We       <= 1'b0;
            ReadData_Out <= '0;
            Timeout_Out  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          ReadData_Out <= '0;
          Timeout_Out  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
